phy_tx_scheduler: RTL and testbench
===================================

# phy_tx_scheduler

Transmit-side sequencer for the PCIe PHY datapath. It owns the 2-bit `CONTROL` select of the PHY input mux and arbitrates three traffic sources onto the single byte lane: framed data packets, requested ordered sets, and periodic SKIP ordered sets. It also drives the `START_END` and `LOG_COM` symbol inputs of the mux. It sits directly in front of the PHY on the `CLK0` domain and hands bytes to data and ordered-set sources through per-source acknowledge strobes.

## Interface
- `SKIP_INTERVAL`, 64: cycles between forced SKIP ordered sets, range 8..65535.
- `OS_LEN`, 4: symbols per ordered set including COM, range 2..16.
- `MAX_PKT`, 16: maximum data bytes per packet before a forced END, range 1..255.

- `CLK` in 1: clock; the PHY `CLK0` domain.
- `RESET_L` in 1: asynchronous, active-low reset.
- `D_REQ` in 1: data source has a packet pending.
- `D_LAST` in 1: the current data byte is the final byte of the packet; only meaningful while `D_ACK`=1.
- `OS_REQ` in 1: an ordered set is requested.
- `D_ACK` out 1: the data byte is consumed this cycle.
- `OS_ACK` out 1: the ordered-set body byte is consumed this cycle.
- `OS_KIND` out 1: 1 = current ordered set is SKIP, 0 = requested.
- `CONTROL` out 2: mux select; 00 D, 01 START_END, 10 ORDERED_SET, 11 LOG_COM.
- `START_END` out 8: 0xFB (STP) or 0xFD (END).
- `LOG_COM` out 8: constant 0xBC.
- `VALID` out 1: the lane carries a symbol this cycle.
- `PKT_ERR` out 1: one-cycle pulse on a forced END.

## Operation
- FSM states: IDLE, STP, DATA, END, COM, OS. All outputs are decoded from registered state and counters (Moore). There is no combinational input-to-output path.
- Outputs by state:
  - IDLE: `VALID`=0, `CONTROL`=00.
  - STP: `CONTROL`=01, `START_END`=0xFB, `VALID`=1.
  - DATA: `CONTROL`=00, `VALID`=1, `D_ACK`=1.
  - END: `CONTROL`=01, `START_END`=0xFD, `VALID`=1.
  - COM: `CONTROL`=11, `VALID`=1.
  - OS: `CONTROL`=10, `VALID`=1, `OS_ACK`=1.
- IDLE arbitration uses fixed priority, evaluated at each clock edge in IDLE:
  1. `skip_due` -> COM with `OS_KIND`=1.
  2. `OS_REQ` -> COM with `OS_KIND`=0.
  3. `D_REQ` -> STP.
  4. Otherwise, stay in IDLE.
- Transitions:
  - STP -> DATA.
  - DATA -> END when `D_LAST`=1 or the byte count equals `MAX_PKT`.
  - END -> IDLE.
  - COM -> OS.
  - OS -> IDLE after `OS_LEN`-1 cycles.
- Byte counter: 8 bits, cleared in STP, incremented each DATA cycle.
  - If the count reaches `MAX_PKT` with `D_LAST`=0, the FSM enters END and pulses `PKT_ERR` in the END cycle.
  - The source is responsible for discarding the remainder of that packet.
- `D_REQ` and `OS_REQ` are ignored outside IDLE. Requests are never preempted; a SKIP waits for packet or ordered-set completion.
- `OS_KIND` is latched on entry to COM and held through OS.
- SKIP counter: 16 bits, counts every cycle and saturates at `SKIP_INTERVAL`.
  - `skip_due` = (count == `SKIP_INTERVAL`).
  - The counter clears to 0 on the edge entering COM with `OS_KIND`=1.
  - Saturation holds `skip_due` high until serviced.
- A requested ordered set does not clear the SKIP counter.

## Timing
- Reset values:
  - State IDLE, both counters 0.
  - `CONTROL`=00, `VALID`=0, `D_ACK`=0, `OS_ACK`=0, `OS_KIND`=0, `PKT_ERR`=0.
  - `START_END`=0x00; `LOG_COM`=0xBC at all times.
- Reset mid-operation aborts immediately. No END or remaining OS symbols are emitted.
- Data packet latency: with `D_REQ` sampled at edge k:
  - STP in cycle k+1.
  - First `D_ACK` in cycle k+2.
  - An N-byte packet occupies N+2 valid cycles.
- Ordered set: COM in cycle k+1, then `OS_LEN`-1 `OS_ACK` cycles.
- Exactly one IDLE (`VALID`=0) cycle follows every END and every final OS cycle before the next arbitration. Back-to-back traffic therefore has a one-cycle gap.
- `skip_due` and `OS_REQ` both asserted in IDLE: SKIP wins, and the requested ordered set follows after the IDLE gap.
- `D_LAST`=1 in the same cycle the count reaches `MAX_PKT`: normal END, no `PKT_ERR`.

## Test plan
- Reset release with no requests for 10 cycles -> `VALID`=0, `CONTROL`=00 throughout, `LOG_COM`=0xBC.
- `D_REQ`=1 and 3-byte packet (`D_LAST` on the 3rd ack) -> `CONTROL` sequence 01,00,00,00,01; `START_END` 0xFB then 0xFD; 3 `D_ACK` pulses; then one IDLE cycle.
- `OS_REQ`=1 with `OS_LEN`=4 -> `CONTROL` 11,10,10,10; 3 `OS_ACK` pulses; `OS_KIND`=0.
- Continuous `D_REQ` with 20-byte packets and `MAX_PKT`=16 -> END after the 16th `D_ACK`, `PKT_ERR` pulses once in the END cycle.
- Continuous `D_REQ` with `SKIP_INTERVAL`=64 -> SKIP (`OS_KIND`=1) emitted at the first IDLE after cycle 64, never inside a packet; `OS_REQ` and skip simultaneous -> SKIP first.
- `RESET_L` asserted in DATA -> all outputs at reset values immediately; after release, the next packet starts with STP and a zeroed byte count.

Source files
------------

// File: rtl/phy_tx_scheduler_if.sv
// Bundle between the transmit scheduler and its sources/PHY mux.
//
// Handshake semantics: D_ACK and OS_ACK are consume strobes, not
// valid/ready pairs. A source that raises D_REQ or OS_REQ holds it until
// it sees its packet or ordered set start on the lane. The data source
// must present a byte in every cycle in which D_ACK is high, and it marks
// the final byte by raising D_LAST in that same cycle. VALID high means
// the lane carries a symbol this cycle. All scheduler outputs are Moore
// outputs, so a source may react combinationally to D_ACK without forming
// a loop.
interface phy_tx_scheduler_if;
  logic       D_REQ;
  logic       D_LAST;
  logic       OS_REQ;
  logic       D_ACK;
  logic       OS_ACK;
  logic       OS_KIND;
  logic [1:0] CONTROL;
  logic [7:0] START_END;
  logic [7:0] LOG_COM;
  logic       VALID;
  logic       PKT_ERR;
  logic [2:0] DBG_STATE;

  modport master (
    input  D_REQ, D_LAST, OS_REQ,
    output D_ACK, OS_ACK, OS_KIND, CONTROL, START_END, LOG_COM,
           VALID, PKT_ERR, DBG_STATE
  );

  modport slave (
    output D_REQ, D_LAST, OS_REQ,
    input  D_ACK, OS_ACK, OS_KIND, CONTROL, START_END, LOG_COM,
           VALID, PKT_ERR, DBG_STATE
  );
endinterface

// File: rtl/phy_tx_scheduler.sv
// Transmit-side sequencer for the PHY byte lane. It arbitrates framed data
// packets, requested ordered sets and periodic SKIP ordered sets, and it
// drives the mux select and symbol inputs. All outputs are Moore outputs.
module phy_tx_scheduler #(
  parameter int unsigned SKIP_INTERVAL = 64,
  parameter int unsigned OS_LEN        = 4,
  parameter int unsigned MAX_PKT       = 16
) (
  input logic               CLK,
  input logic               RESET_L,
  phy_tx_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_STP  = 3'd1,
    S_DATA = 3'd2,
    S_END  = 3'd3,
    S_COM  = 3'd4,
    S_OS   = 3'd5
  } state_t;

  localparam logic [15:0] SKIP_MAX = 16'(SKIP_INTERVAL);
  localparam logic [7:0]  PKT_MAX  = 8'(MAX_PKT);
  // The OS counter starts at 0 in the first body cycle, so the final body
  // cycle is the one where the counter equals OS_LEN-2.
  localparam logic [3:0]  OS_LAST  = 4'(OS_LEN - 2);

  state_t      state_q, state_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [3:0]  os_cnt_q, os_cnt_d;
  logic [15:0] skip_cnt_q, skip_cnt_d;
  logic        os_kind_q, os_kind_d;
  logic        err_q, err_d;

  logic        skip_due;
  logic        byte_limit;

  assign skip_due   = (skip_cnt_q == SKIP_MAX);
  // True in the DATA cycle that carries byte number MAX_PKT.
  assign byte_limit = ((byte_cnt_q + 8'd1) == PKT_MAX);

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 8'd0;
      os_cnt_q   <= 4'd0;
      skip_cnt_q <= 16'd0;
      os_kind_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      os_cnt_q   <= os_cnt_d;
      skip_cnt_q <= skip_cnt_d;
      os_kind_q  <= os_kind_d;
      err_q      <= err_d;
    end
  end

  // Next state: fixed-priority arbitration in IDLE, no preemption elsewhere.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    os_cnt_d   = os_cnt_q;
    os_kind_d  = os_kind_q;
    err_d      = err_q;
    // The SKIP counter free-runs and saturates so skip_due stays asserted
    // until the scheduler gets back to IDLE and services it.
    skip_cnt_d = skip_due ? skip_cnt_q : (skip_cnt_q + 16'd1);

    case (state_q)
      S_IDLE: begin
        if (skip_due) begin
          state_d    = S_COM;
          os_kind_d  = 1'b1;
          skip_cnt_d = 16'd0;
        end else if (bus.OS_REQ) begin
          state_d   = S_COM;
          os_kind_d = 1'b0;
        end else if (bus.D_REQ) begin
          state_d = S_STP;
        end
      end
      S_STP: begin
        byte_cnt_d = 8'd0;
        state_d    = S_DATA;
      end
      S_DATA: begin
        byte_cnt_d = byte_cnt_q + 8'd1;
        if (bus.D_LAST || byte_limit) begin
          state_d = S_END;
          // Only a length overrun without D_LAST is an error.
          err_d   = byte_limit && !bus.D_LAST;
        end
      end
      S_END: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_COM: begin
        os_cnt_d = 4'd0;
        state_d  = S_OS;
      end
      S_OS: begin
        os_cnt_d = os_cnt_q + 4'd1;
        if (os_cnt_q == OS_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Lane outputs decoded purely from registered state.
  always_comb begin
    bus.VALID     = 1'b0;
    bus.CONTROL   = 2'b00;
    bus.START_END = 8'h00;
    bus.D_ACK     = 1'b0;
    bus.OS_ACK    = 1'b0;
    case (state_q)
      S_STP: begin
        bus.VALID     = 1'b1;
        bus.CONTROL   = 2'b01;
        bus.START_END = 8'hFB;
      end
      S_DATA: begin
        bus.VALID = 1'b1;
        bus.D_ACK = 1'b1;
      end
      S_END: begin
        bus.VALID     = 1'b1;
        bus.CONTROL   = 2'b01;
        bus.START_END = 8'hFD;
      end
      S_COM: begin
        bus.VALID   = 1'b1;
        bus.CONTROL = 2'b11;
      end
      S_OS: begin
        bus.VALID   = 1'b1;
        bus.CONTROL = 2'b10;
        bus.OS_ACK  = 1'b1;
      end
      default: begin
        bus.VALID = 1'b0;
      end
    endcase
  end

  assign bus.LOG_COM   = 8'hBC;
  assign bus.OS_KIND   = os_kind_q;
  assign bus.PKT_ERR   = (state_q == S_END) && err_q;
  assign bus.DBG_STATE = state_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: directed traffic, expected lane symbols
// queued at issue time and checked by an independent lane monitor.
module tb_phy_tx_scheduler;

  logic CLK = 1'b0;
  logic RESET_L = 1'b0;

  // Clock block.
  always #5 CLK = ~CLK;

  phy_tx_scheduler_if bus();

  phy_tx_scheduler #(
    .SKIP_INTERVAL(64),
    .OS_LEN(4),
    .MAX_PKT(16)
  ) dut (
    .CLK(CLK),
    .RESET_L(RESET_L),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Expected lane symbol: {CONTROL, START_END, D_ACK, OS_ACK, OS_KIND, PKT_ERR}
  logic [13:0] exp_q[$];
  logic [13:0] act_sym;
  logic [13:0] exp_sym;
  logic        gap_chk = 1'b0;
  logic        seen_valid = 1'b0;
  int          idle_run = 0;

  function automatic logic [13:0] pk(input logic [1:0] c, input logic [7:0] se,
                                     input logic da, input logic oa,
                                     input logic k, input logic e);
    return {c, se, da, oa, k, e};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard monitor: pops one expected symbol per valid lane cycle.
  always @(negedge CLK) begin
    if (RESET_L) begin
      if (bus.VALID) begin
        if (gap_chk && seen_valid && idle_run > 0) check("idle_gap", idle_run, 1);
        seen_valid = 1'b1;
        idle_run   = 0;
        act_sym = {bus.CONTROL, bus.START_END, bus.D_ACK, bus.OS_ACK,
                   (bus.CONTROL[1] ? bus.OS_KIND : 1'b0), bus.PKT_ERR};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_symbol: got %0h with nothing expected at %0t", act_sym, $time);
        end else begin
          exp_sym = exp_q.pop_front();
          check("lane_symbol", act_sym, exp_sym);
        end
      end else begin
        idle_run++;
        check("idle_outputs", {bus.CONTROL, bus.START_END, bus.D_ACK, bus.OS_ACK, bus.PKT_ERR}, 0);
        check("log_com", bus.LOG_COM, 8'hBC);
      end
    end else begin
      seen_valid = 1'b0;
      idle_run   = 0;
    end
  end

  // Expected symbols of an n-byte packet with MAX_PKT = 16.
  task automatic push_pkt(input int n);
    int m;
    m = (n > 16) ? 16 : n;
    exp_q.push_back(pk(2'b01, 8'hFB, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < m; i++) exp_q.push_back(pk(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(pk(2'b01, 8'hFD, 1'b0, 1'b0, 1'b0, (n > 16)));
  endtask

  // Expected symbols of one ordered set with OS_LEN = 4.
  task automatic push_os(input logic kind);
    exp_q.push_back(pk(2'b11, 8'h00, 1'b0, 1'b0, kind, 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(pk(2'b10, 8'h00, 1'b0, 1'b1, kind, 1'b0));
  endtask

  task automatic do_reset();
    RESET_L    = 1'b0;
    bus.D_REQ  = 1'b0;
    bus.D_LAST = 1'b0;
    bus.OS_REQ = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_outputs", {bus.VALID, bus.CONTROL, bus.START_END, bus.D_ACK,
                          bus.OS_ACK, bus.OS_KIND, bus.PKT_ERR}, 0);
    check("rst_log_com", bus.LOG_COM, 8'hBC);
    check("rst_state", bus.DBG_STATE, 0);
    @(negedge CLK);
    RESET_L = 1'b1;
  endtask

  // Data source driver: requests, then feeds bytes on D_ACK, marking byte n last.
  task automatic send_pkt(input int n, input bit raise_os);
    int  acks;
    int  guard;
    bit  done;
    acks  = 0;
    guard = 0;
    done  = 0;
    push_pkt(n);
    bus.D_REQ = 1'b1;
    while (!done && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
      if (bus.VALID && bus.CONTROL == 2'b01 && bus.START_END == 8'hFB) done = 1;
    end
    bus.D_REQ = 1'b0;
    if (!done) timeout("stp_wait");
    if (raise_os) bus.OS_REQ = 1'b1;
    done  = 0;
    guard = 0;
    while (!done && guard < 300) begin
      @(posedge CLK); #1;
      guard++;
      if (bus.D_ACK) begin
        acks++;
        bus.D_LAST = (acks == n);
      end else begin
        bus.D_LAST = 1'b0;
      end
      if (bus.VALID && bus.CONTROL == 2'b01 && bus.START_END == 8'hFD) done = 1;
    end
    bus.D_LAST = 1'b0;
    if (!done) timeout("end_wait");
    check("d_ack_count", acks, (n > 16) ? 16 : n);
  endtask

  // Holds OS_REQ until the requested ordered set starts.
  task automatic wait_req_com();
    int guard;
    bit done;
    guard = 0;
    done  = 0;
    while (!done && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
      if (bus.VALID && bus.CONTROL == 2'b11 && bus.OS_KIND == 1'b0) done = 1;
    end
    bus.OS_REQ = 1'b0;
    if (!done) timeout("os_com_wait");
  endtask

  task automatic wait_quiet();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.VALID) && guard < 300) begin
      @(posedge CLK); #1;
      guard++;
    end
    if (guard >= 300) timeout("drain");
    repeat (2) @(negedge CLK);
  endtask

  // Driver sequence.
  initial begin
    bus.D_REQ  = 1'b0;
    bus.D_LAST = 1'b0;
    bus.OS_REQ = 1'b0;

    // Quiet lane after reset release.
    do_reset();
    repeat (10) @(negedge CLK);

    // Three-byte packet, then back to idle.
    do_reset();
    send_pkt(3, 1'b0);
    wait_quiet();

    // Requested ordered set.
    do_reset();
    push_os(1'b0);
    bus.OS_REQ = 1'b1;
    wait_req_com();
    wait_quiet();

    // Overlong packet forces END with PKT_ERR; then D_LAST exactly at the limit.
    do_reset();
    send_pkt(20, 1'b0);
    send_pkt(16, 1'b0);
    wait_quiet();

    // Reset in the middle of a packet.
    do_reset();
    begin
      int guard;
      int acks;
      bit done;
      guard = 0;
      acks  = 0;
      done  = 0;
      exp_q.push_back(pk(2'b01, 8'hFB, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++) exp_q.push_back(pk(2'b00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
      bus.D_REQ = 1'b1;
      while (acks < 3 && guard < 100) begin
        @(posedge CLK); #1;
        guard++;
        if (bus.VALID) bus.D_REQ = 1'b0;
        if (bus.D_ACK) acks++;
      end
      if (acks < 3) timeout("mid_pkt_acks");
      @(negedge CLK);
      #1;
      RESET_L = 1'b0;
      #1;
      check("async_rst_outputs", {bus.VALID, bus.CONTROL, bus.START_END, bus.D_ACK,
                                  bus.OS_ACK, bus.OS_KIND, bus.PKT_ERR}, 0);
      check("async_rst_state", bus.DBG_STATE, 0);
      check("mid_pkt_drained", exp_q.size(), 0);
      exp_q.delete();
      @(negedge CLK);
      RESET_L = 1'b1;
      send_pkt(16, 1'b0);
      wait_quiet();
    end

    // Continuous 10-byte packets: 13-cycle period, arbitration edges
    // 1,14,27,40,53,66. The SKIP counter saturates at edge 64, so the SKIP
    // goes out at edge 66 after packet 4; OS_REQ raised during packet 4
    // follows the SKIP, then data resumes. Every gap is one idle cycle.
    do_reset();
    gap_chk = 1'b1;
    for (int p = 0; p < 5; p++) send_pkt(10, (p == 4));
    push_os(1'b1);
    push_os(1'b0);
    wait_req_com();
    send_pkt(10, 1'b0);
    wait_quiet();
    gap_chk = 1'b0;

    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
